indication_output_queue: RTL and testbench

Parametrised indication serializer that sits between an indication interface with NUM_METH methods and a single outbound message pipe. Each method call is captured in a per-method staging register, and a round-robin arbiter moves one staged call per cycle into a DEPTH-entry FIFO. The FIFO head drives the pipe as a tagged word {arg, tag}. It generalises the earlier two-entry ping-pong output block to N methods, arbitrary depth and full back-pressure, with no lost or reordered calls per method.

---
 rtl/indq_pkg.sv | 24 ++
 rtl/indq_fifo.sv | 57 +++++
 rtl/indication_output_queue.sv | 98 +++++++++
 tb/tb_indication_output_queue.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/indq_pkg.sv
// Shared constants, helpers and the default tagged-word layout for the
// indication output queue.
package indq_pkg;

    // Tags are method index + TAG_BASE so that tag 0 never appears on the pipe.
    localparam int TAG_BASE = 1;

    localparam int IND_ARG_W = 64;
    localparam int IND_TAG_W = 32;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    typedef struct packed {
        logic [IND_ARG_W-1:0] arg;
        logic [IND_TAG_W-1:0] tag;
    } indq_word_t;

endpackage

// File: rtl/indq_fifo.sv
// Synchronous FIFO with separate occupancy counter; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module indq_fifo
    import indq_pkg::*;
#(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic [WIDTH-1:0]            head,
    output logic [clog2(DEPTH+1)-1:0]   count,
    output logic                        full,
    output logic                        empty
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Empty FIFO presents zero rather than a stale entry.
    assign head = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/indication_output_queue.sv
// Serializes NUM_METH indication methods into one tagged pipe: per-method
// staging registers, a round-robin arbiter, and a DEPTH-entry FIFO.
module indication_output_queue
    import indq_pkg::*;
#(
    parameter int NUM_METH  = 4,
    parameter int ARG_WIDTH = 64,
    parameter int DEPTH     = 4,
    parameter int TAG_WIDTH = 32
) (
    input  logic                            CLK,
    input  logic                            nRST,
    input  logic [NUM_METH-1:0]             ind_ena,
    input  logic [NUM_METH*ARG_WIDTH-1:0]   ind_arg,
    output logic [NUM_METH-1:0]             ind_rdy,
    output logic                            pipe_enq_ena,
    output logic [ARG_WIDTH+TAG_WIDTH-1:0]  pipe_enq_v,
    input  logic                            pipe_enq_rdy,
    output logic [clog2(DEPTH+1)-1:0]       count
);

    localparam int PW = (NUM_METH > 1) ? clog2(NUM_METH) : 1;
    localparam int WW = ARG_WIDTH + TAG_WIDTH;

    logic [NUM_METH-1:0]                stage_valid;
    logic [NUM_METH-1:0][ARG_WIDTH-1:0] stage_arg;
    logic [PW-1:0]                      rr_ptr;
    logic [PW-1:0]                      rr_next;
    logic [PW-1:0]                      gnt_idx;
    logic                               gnt_found;
    logic                               grant;
    logic                               pop;
    logic                               full;
    logic                               empty;
    logic [WW-1:0]                      push_word;
    int                                 idx;

    assign ind_rdy = ~stage_valid;

    // First staged method at or after rr_ptr, wrapping around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NUM_METH; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_METH) idx = idx - NUM_METH;
            if (!gnt_found && stage_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = PW'(idx);
            end
        end
    end

    assign pop       = pipe_enq_ena & pipe_enq_rdy;
    assign grant     = gnt_found & (~full | pop);
    assign push_word = {stage_arg[gnt_idx], TAG_WIDTH'(gnt_idx) + TAG_WIDTH'(TAG_BASE)};
    assign rr_next   = (int'(gnt_idx) == NUM_METH - 1) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge CLK) begin
        if (!nRST) rr_ptr <= '0;
        else if (grant) rr_ptr <= rr_next;
    end

    // A fresh accept wins over a grant clearing the same slot.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            stage_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_METH; i++) begin
                if (ind_ena[i] && ind_rdy[i]) begin
                    stage_valid[i] <= 1'b1;
                    stage_arg[i]   <= ind_arg[i*ARG_WIDTH +: ARG_WIDTH];
                end else if (grant && int'(gnt_idx) == i) begin
                    stage_valid[i] <= 1'b0;
                end
            end
        end
    end

    indq_fifo #(
        .WIDTH (WW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .nRST      (nRST),
        .push      (grant),
        .push_data (push_word),
        .pop       (pop),
        .head      (pipe_enq_v),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign pipe_enq_ena = ~empty;

endmodule

// File: tb/tb_indication_output_queue.sv
// Directed bench for indication_output_queue with default parameters
// (4 methods, 64-bit args, depth 4, 32-bit tags).
module tb_indication_output_queue;
    import indq_pkg::*;

    logic         CLK = 1'b0;
    logic         nRST;
    logic [3:0]   ind_ena;
    logic [255:0] ind_arg;
    logic [3:0]   ind_rdy;
    logic         pipe_enq_ena;
    logic [95:0]  pipe_enq_v;
    logic         pipe_enq_rdy;
    logic [2:0]   count;

    int checks = 0;
    int errors = 0;

    indication_output_queue #(
        .NUM_METH  (4),
        .ARG_WIDTH (64),
        .DEPTH     (4),
        .TAG_WIDTH (32)
    ) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .ind_ena      (ind_ena),
        .ind_arg      (ind_arg),
        .ind_rdy      (ind_rdy),
        .pipe_enq_ena (pipe_enq_ena),
        .pipe_enq_v   (pipe_enq_v),
        .pipe_enq_rdy (pipe_enq_rdy),
        .count        (count)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [95:0] word(input logic [63:0] a, input int t);
        indq_word_t w;
        w.arg = a;
        w.tag = 32'(t);
        return w;
    endfunction

    task automatic do_reset();
        nRST = 1'b0;
        ind_ena = '0;
        pipe_enq_rdy = 1'b0;
        tick();
        tick();
        nRST = 1'b1;
    endtask

    // Waits (bounded) for method m to be ready, then issues one call.
    task automatic call(input int m, input logic [63:0] a);
        int n;
        n = 0;
        while (ind_rdy[m] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL call_wait_rdy m=%0d: ind_rdy=%b never went high, required 1", m, ind_rdy[m]);
        end
        ind_ena[m] = 1'b1;
        ind_arg[m*64 +: 64] = a;
        tick();
        ind_ena = '0;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        ind_ena = 4'hF;
        ind_arg = '1;
        pipe_enq_rdy = 1'b1;
        tick();
        tick();
        checks++; if (ind_rdy !== 4'b1111) begin errors++; $display("FAIL reset_rdy: got %b required 1111", ind_rdy); end
        checks++; if (pipe_enq_ena !== 1'b0) begin errors++; $display("FAIL reset_ena: got %b required 0", pipe_enq_ena); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d required 0", count); end
        checks++; if (pipe_enq_v !== 96'd0) begin errors++; $display("FAIL reset_v: got %h required 0", pipe_enq_v); end
        nRST = 1'b1;
        ind_ena = '0;
        ind_arg = '0;
        pipe_enq_rdy = 1'b0;
    endtask

    task automatic test_single_call();
        do_reset();
        pipe_enq_rdy = 1'b1;
        ind_ena[2] = 1'b1;
        ind_arg[128 +: 64] = 64'hDEAD;
        tick();
        ind_ena = '0;
        checks++; if (ind_rdy !== 4'b1011) begin errors++; $display("FAIL single_staged_rdy: got %b required 1011", ind_rdy); end
        checks++; if (pipe_enq_ena !== 1'b0) begin errors++; $display("FAIL single_early_ena: got %b required 0", pipe_enq_ena); end
        tick();
        checks++; if (pipe_enq_ena !== 1'b1) begin errors++; $display("FAIL single_ena: got %b required 1", pipe_enq_ena); end
        checks++; if (pipe_enq_v !== word(64'hDEAD, 3)) begin errors++; $display("FAIL single_v: got %h required %h", pipe_enq_v, word(64'hDEAD, 3)); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d required 1", count); end
        tick();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_drain_count: got %0d required 0", count); end
        checks++; if (pipe_enq_v !== 96'd0) begin errors++; $display("FAIL single_drain_v: got %h required 0", pipe_enq_v); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        pipe_enq_rdy = 1'b1;
        for (int r = 0; r < 2; r++) begin
            ind_ena = 4'hF;
            for (int m = 0; m < 4; m++) ind_arg[m*64 +: 64] = 64'(10 + m);
            tick();
            ind_ena = '0;
            checks++; if (ind_rdy !== 4'b0000) begin errors++; $display("FAIL simul_rdy r=%0d: got %b required 0000", r, ind_rdy); end
            for (int k = 0; k < 4; k++) begin
                tick();
                checks++;
                if (pipe_enq_ena !== 1'b1 || pipe_enq_v !== word(64'(10 + k), k + 1)) begin
                    errors++;
                    $display("FAIL simul_word r=%0d k=%0d: got ena=%b v=%h required ena=1 v=%h", r, k, pipe_enq_ena, pipe_enq_v, word(64'(10 + k), k + 1));
                end
            end
            tick();
            checks++; if (count !== 3'd0) begin errors++; $display("FAIL simul_drain r=%0d: got %0d required 0", r, count); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        pipe_enq_rdy = 1'b0;
        for (int n = 1; n <= 5; n++) call(0, 64'(n));
        tick();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL bp_count_sat: got %0d required 4", count); end
        checks++; if (ind_rdy[0] !== 1'b0) begin errors++; $display("FAIL bp_rdy0: got %b required 0", ind_rdy[0]); end
        ind_ena[0] = 1'b1;
        ind_arg[63:0] = 64'd6;
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (pipe_enq_ena !== 1'b1 || pipe_enq_v !== word(64'd1, 1)) begin
                errors++;
                $display("FAIL bp_stall_v s=%0d: got ena=%b v=%h required ena=1 v=%h", s, pipe_enq_ena, pipe_enq_v, word(64'd1, 1));
            end
            tick();
        end
        ind_ena = '0;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL bp_count_hold: got %0d required 4", count); end
        pipe_enq_rdy = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            checks++;
            if (pipe_enq_ena !== 1'b1 || pipe_enq_v !== word(64'(n), 1)) begin
                errors++;
                $display("FAIL bp_drain n=%0d: got ena=%b v=%h required ena=1 v=%h", n, pipe_enq_ena, pipe_enq_v, word(64'(n), 1));
            end
            tick();
        end
        checks++; if (pipe_enq_ena !== 1'b0) begin errors++; $display("FAIL bp_empty_ena: got %b required 0", pipe_enq_ena); end
        tick();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL bp_no_call6: got count %0d required 0", count); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        pipe_enq_rdy = 1'b0;
        for (int k = 0; k < 4; k++) call(1, 64'h100 + 64'(k));
        call(2, 64'h200);
        tick();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d required 4", count); end
        checks++; if (ind_rdy !== 4'b1011) begin errors++; $display("FAIL full_staged_rdy: got %b required 1011", ind_rdy); end
        pipe_enq_rdy = 1'b1;
        checks++; if (pipe_enq_v !== word(64'h100, 2)) begin errors++; $display("FAIL full_head: got %h required %h", pipe_enq_v, word(64'h100, 2)); end
        tick();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_pushpop_count: got %0d required 4", count); end
        checks++; if (ind_rdy !== 4'b1111) begin errors++; $display("FAIL full_pushpop_rdy: got %b required 1111", ind_rdy); end
        for (int k = 1; k < 4; k++) begin
            checks++;
            if (pipe_enq_v !== word(64'h100 + 64'(k), 2)) begin
                errors++;
                $display("FAIL full_drain k=%0d: got %h required %h", k, pipe_enq_v, word(64'h100 + 64'(k), 2));
            end
            tick();
        end
        checks++; if (pipe_enq_v !== word(64'h200, 3)) begin errors++; $display("FAIL full_last: got %h required %h", pipe_enq_v, word(64'h200, 3)); end
        tick();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL full_empty: got %0d required 0", count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pipe_enq_rdy = 1'b0;
        for (int k = 1; k <= 3; k++) call(0, 64'hA0 + 64'(k));
        ind_ena = 4'b0110;
        ind_arg[64 +: 64]  = 64'hB1;
        ind_arg[128 +: 64] = 64'hC1;
        tick();
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL mid_pre_count: got %0d required 3", count); end
        checks++; if (ind_rdy !== 4'b1001) begin errors++; $display("FAIL mid_pre_rdy: got %b required 1001", ind_rdy); end
        nRST = 1'b0;
        ind_ena = 4'hF;
        tick();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_count: got %0d required 0", count); end
        checks++; if (pipe_enq_ena !== 1'b0) begin errors++; $display("FAIL mid_ena: got %b required 0", pipe_enq_ena); end
        checks++; if (ind_rdy !== 4'b1111) begin errors++; $display("FAIL mid_rdy: got %b required 1111", ind_rdy); end
        nRST = 1'b1;
        ind_ena = '0;
        pipe_enq_rdy = 1'b1;
        for (int s = 0; s < 4; s++) begin
            tick();
            checks++;
            if (pipe_enq_ena !== 1'b0 || pipe_enq_v !== 96'd0) begin
                errors++;
                $display("FAIL mid_stale s=%0d: got ena=%b v=%h required ena=0 v=0", s, pipe_enq_ena, pipe_enq_v);
            end
        end
        call(3, 64'h77);
        tick();
        checks++; if (pipe_enq_v !== word(64'h77, 4)) begin errors++; $display("FAIL mid_after: got %h required %h", pipe_enq_v, word(64'h77, 4)); end
    endtask

    initial begin
        nRST = 1'b0;
        ind_ena = '0;
        ind_arg = '0;
        pipe_enq_rdy = 1'b0;
        test_reset();
        test_single_call();
        test_simultaneous();
        test_backpressure();
        test_full_push_pop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule
